// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: definitions shared by the 16-bit pipelined CPU.
//   PC_W        address / instruction width
//   HLT_OPCODE  opcode (Instr[15:12]) of the HLT instruction
//   NOP_INSTR   encoding of a pipeline bubble
//   fetch_state_e  fetch-stage FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  localparam logic [PC_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/dff_en16.sv
// ---------------------------------------------------------------------------
// dff_en16: 16-bit register with synchronous active-high reset and load
// enable. Reset has priority over the enable.
//   clk  clock (rising edge)
//   rst  synchronous reset, loads RST_VAL
//   en   load enable
//   d    next value
//   q    registered value
// ---------------------------------------------------------------------------
module dff_en16 #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : dff_en16

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage. Holds the architectural PC, loads the
// IF/ID pipeline register, and handles stall, flush (redirect) and the HLT
// shutdown sequence.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   Instr         instruction read combinationally from imem at PC
//   PC_Target     redirect address; bit 0 is dropped
//   Flush         squash IF/ID and redirect PC to PC_Target
//   Stall         hold PC, IF/ID and FSM state
//   PC            current fetch address
//   IFID_Instr    registered instruction
//   IFID_PCPlus2  registered PC+2 of that instruction
//   IFID_Valid    IF/ID holds a live instruction
//   Halted        fetch permanently stopped (until rst)
//   fetch_state   FSM state, for observation
//
// Optional build macro FETCH_PERF_EN adds FetchCount / StallCount, two
// saturating 16-bit event counters.
//
// Handshake: there is no valid/ready pair here. Stall is a hold request that
// freezes all stage state on the edge it is sampled high; Flush overrides it.
// ---------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  OPC_HLT  = HLT_OPCODE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  Instr,
  input  logic [15:0]  PC_Target,
  input  logic         Flush,
  input  logic         Stall,
  output logic [15:0]  PC,
  output logic [15:0]  IFID_Instr,
  output logic [15:0]  IFID_PCPlus2,
  output logic         IFID_Valid,
  output logic         Halted,
`ifdef FETCH_PERF_EN
  output logic [15:0]  FetchCount,
  output logic [15:0]  StallCount,
`endif
  output fetch_state_e fetch_state
);

  fetch_state_e state, state_next;

  logic [15:0] pc_plus2;
  logic        is_hlt;
  logic        active;

  logic        pc_en,   ir_en,   pp2_en;
  logic [15:0] pc_d,    ir_d;
  logic        valid_d;

  // Wraps silently at 16'hFFFE -> 16'h0000.
  assign pc_plus2 = PC + 16'd2;
  assign is_hlt   = (Instr[15:12] == OPC_HLT);
  // Once HALTED, Flush and Stall no longer have any effect.
  assign active   = (state != HALTED);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (!Flush && !Stall && is_hlt) begin
          state_next = HALT_PEND;
        end
      end
      HALT_PEND: begin
        // The HLT is in ID and can still be squashed by an older branch.
        if (Flush) begin
          state_next = FETCH;
        end else if (!Stall) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // ---- FSM: output / datapath control ----
  always_comb begin
    pc_en   = 1'b0;
    pc_d    = pc_plus2;
    ir_en   = 1'b0;
    ir_d    = Instr;
    pp2_en  = 1'b0;
    valid_d = IFID_Valid;

    if (active && Flush) begin
      pc_en   = 1'b1;
      pc_d    = {PC_Target[15:1], 1'b0};
      ir_en   = 1'b1;
      ir_d    = NOP_INSTR;
      valid_d = 1'b0;
    end else if (active && Stall) begin
      // Everything holds.
    end else begin
      case (state)
        FETCH: begin
          ir_en   = 1'b1;
          pp2_en  = 1'b1;
          valid_d = 1'b1;
          // A fetched HLT freezes the PC on itself.
          pc_en   = !is_hlt;
        end
        HALT_PEND: begin
          valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // ---- Datapath registers ----
  dff_en16 #(.RST_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (PC)
  );

  dff_en16 #(.RST_VAL(NOP_INSTR)) u_ifid_instr (
    .clk (clk),
    .rst (rst),
    .en  (ir_en),
    .d   (ir_d),
    .q   (IFID_Instr)
  );

  dff_en16 #(.RST_VAL(16'h0000)) u_ifid_pcplus2 (
    .clk (clk),
    .rst (rst),
    .en  (pp2_en),
    .d   (pc_plus2),
    .q   (IFID_PCPlus2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      IFID_Valid <= 1'b0;
    end else begin
      IFID_Valid <= valid_d;
    end
  end

  assign Halted      = (state == HALTED);
  assign fetch_state = state;

`ifdef FETCH_PERF_EN
  logic fetch_evt, stall_evt;

  // A fetch event is exactly an edge where IFID_Valid is loaded with 1.
  assign fetch_evt = (state == FETCH) && !Flush && !Stall;
  assign stall_evt = Stall && !Flush && active;

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount <= 16'h0000;
      StallCount <= 16'h0000;
    end else begin
      if (fetch_evt && (FetchCount != 16'hFFFF)) begin
        FetchCount <= FetchCount + 16'd1;
      end
      if (stall_evt && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
    end
  end
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage: self-checking bench for fetch_stage.
// A table of {inputs, expected post-edge outputs} is applied one row per
// clock; each row's expectation is pushed to exp_q when driven and popped
// and compared after the edge. A hand-written HLT sequence follows.
// Build with +define+FETCH_PERF_EN to also cover the perf counters.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import cpu_pkg::*;

  // ---- clock / reset ----
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [15:0]  instr;
  logic [15:0]  pc_target;
  logic         flush;
  logic         stall;
  logic [15:0]  pc;
  logic [15:0]  ifid_instr;
  logic [15:0]  ifid_pcplus2;
  logic         ifid_valid;
  logic         halted;
  fetch_state_e dut_state;
`ifdef FETCH_PERF_EN
  logic [15:0]  fetch_count;
  logic [15:0]  stall_count;
`endif

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .Instr        (instr),
    .PC_Target    (pc_target),
    .Flush        (flush),
    .Stall        (stall),
    .PC           (pc),
    .IFID_Instr   (ifid_instr),
    .IFID_PCPlus2 (ifid_pcplus2),
    .IFID_Valid   (ifid_valid),
    .Halted       (halted),
`ifdef FETCH_PERF_EN
    .FetchCount   (fetch_count),
    .StallCount   (stall_count),
`endif
    .fetch_state  (dut_state)
  );

  // ---- vector table ----
  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic [15:0] instr;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic s,
                              input logic [15:0] in, input logic [15:0] tg,
                              input logic [15:0] epc, input logic [15:0] eir,
                              input logic [15:0] epp2, input logic ev,
                              input logic eh, input logic [1:0] est);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.instr = in; v.tgt = tg;
    v.pc = epc; v.ir = eir; v.pp2 = epp2; v.valid = ev; v.halted = eh; v.st = est;
    return v;
  endfunction

  // ---- scoreboard ----
  logic [51:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- driver ----
  task automatic drive(input logic r, input logic f, input logic s,
                       input logic [15:0] in, input logic [15:0] tg);
    rst = r; flush = f; stall = s; instr = in; pc_target = tg;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic [51:0] e;
    string tag;
    @(negedge clk);
    drive(v.rst, v.flush, v.stall, v.instr, v.tgt);
    exp_q.push_back({v.pc, v.ir, v.pp2, v.valid, v.halted, v.st});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tag = $sformatf("row%0d", idx);
    check({tag, ".pc"},     pc,                   e[51:36]);
    check({tag, ".ir"},     ifid_instr,           e[35:20]);
    check({tag, ".pp2"},    ifid_pcplus2,         e[19:4]);
    check({tag, ".valid"},  {15'd0, ifid_valid},  {15'd0, e[3]});
    check({tag, ".halted"}, {15'd0, halted},      {15'd0, e[2]});
    check({tag, ".state"},  {14'd0, dut_state},   {14'd0, e[1:0]});
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic [15:0] in);
    @(negedge clk);
    drive(r, f, s, in, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    //           rst  fl  st  instr     tgt       pc        ir        pp2      v  h  state
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h1234, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h1234, 16'h0000, 16'h0004, 16'h1234, 16'h0004, 1, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h1234, 16'h0000, 16'h0006, 16'h1234, 16'h0006, 1, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h2222, 16'h0000, 16'h0008, 16'h2222, 16'h0008, 1, 0, FETCH));
    // stall twice at PC 8
    vecs.push_back(mk(0, 0, 1, 16'h3333, 16'h0000, 16'h0008, 16'h2222, 16'h0008, 1, 0, FETCH));
    vecs.push_back(mk(0, 0, 1, 16'h3333, 16'h0000, 16'h0008, 16'h2222, 16'h0008, 1, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h3333, 16'h0000, 16'h000A, 16'h3333, 16'h000A, 1, 0, FETCH));
    // flush + stall, odd target
    vecs.push_back(mk(0, 1, 1, 16'h4444, 16'h0031, 16'h0030, 16'h0000, 16'h000A, 0, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h5555, 16'h0000, 16'h0032, 16'h5555, 16'h0032, 1, 0, FETCH));
    vecs.push_back(mk(0, 1, 0, 16'h5555, 16'h000C, 16'h000C, 16'h0000, 16'h0032, 0, 0, FETCH));
    // HLT at PC C
    vecs.push_back(mk(0, 0, 0, 16'hF000, 16'h0000, 16'h000C, 16'hF000, 16'h000E, 1, 0, HALT_PEND));
    vecs.push_back(mk(0, 0, 0, 16'h1111, 16'h0000, 16'h000C, 16'hF000, 16'h000E, 0, 1, HALTED));
    vecs.push_back(mk(0, 1, 1, 16'h1111, 16'h0050, 16'h000C, 16'hF000, 16'h000E, 0, 1, HALTED));
    vecs.push_back(mk(0, 0, 1, 16'h1111, 16'h0000, 16'h000C, 16'hF000, 16'h000E, 0, 1, HALTED));
    vecs.push_back(mk(0, 1, 0, 16'h1234, 16'h0060, 16'h000C, 16'hF000, 16'h000E, 0, 1, HALTED));
    vecs.push_back(mk(1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, FETCH));
    // HLT then stall in HALT_PEND, then squashed by flush
    vecs.push_back(mk(0, 0, 0, 16'hF123, 16'h0000, 16'h0000, 16'hF123, 16'h0002, 1, 0, HALT_PEND));
    vecs.push_back(mk(0, 0, 1, 16'h1111, 16'h0000, 16'h0000, 16'hF123, 16'h0002, 1, 0, HALT_PEND));
    vecs.push_back(mk(0, 1, 0, 16'h1111, 16'h0040, 16'h0040, 16'h0000, 16'h0002, 0, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h1000, 16'h0000, 16'h0042, 16'h1000, 16'h0042, 1, 0, FETCH));
    // wrap at top of address space
    vecs.push_back(mk(0, 1, 0, 16'h1000, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0042, 0, 0, FETCH));
    vecs.push_back(mk(0, 0, 0, 16'h2000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 1, 0, FETCH));
    // reset beats flush
    vecs.push_back(mk(1, 1, 1, 16'h2000, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 0, FETCH));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(i, vecs[i]);
    end

    // ---- HLT timing: Halted must rise on the second edge after HLT fetch ----
    step(1, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h1234);
    step(0, 0, 0, 16'h1234);
    step(0, 0, 0, 16'h1234);
    step(0, 0, 1, 16'h1234);
    step(0, 0, 1, 16'h1234);
    check("seq.pc_before_hlt", pc, 16'h0006);
    @(negedge clk);
    drive(0, 0, 0, 16'hF000, 16'h0000);
    cnt = 0;
    while (cnt < 8) begin
      @(posedge clk);
      #1;
      cnt++;
      instr = 16'h0000;
      if (halted) break;
    end
    check("seq.halt_latency", cnt[15:0], 16'd2);
    check("seq.pc_frozen", pc, 16'h0006);
    step(0, 0, 1, 16'h0000);
    step(0, 1, 1, 16'h0000);
    check("seq.halted_sticky", {15'd0, halted}, 16'd1);
`ifdef FETCH_PERF_EN
    check("perf.fetch_count", fetch_count, 16'd4);
    check("perf.stall_count", stall_count, 16'd2);
    step(1, 0, 0, 16'h0000);
    check("perf.fetch_reset", fetch_count, 16'd0);
    check("perf.stall_reset", stall_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_fetch_stage
